// File: rtl/imem_ctrl_if.sv
// Bus bundle for the instruction-memory front end: CPU fetch port,
// host/loader port and the imem command/data signals.
//
// Request handshake (both requesters): req and its qualifiers (addr, we,
// hi, wdata) are held stable until the cycle in which gnt=1; that cycle is
// the accept. gnt is combinational and can be high on consecutive cycles.
// Read data comes back as a one-cycle rvalid pulse; rdata keeps its value
// between pulses. There is no back-pressure on the read data.
interface imem_ctrl_if #(
    parameter int WIDTH    = 28,
    parameter int ADD_SIZE = 11
);
    // CPU fetch port
    logic                cpu_req;
    logic [ADD_SIZE-1:0] cpu_addr;
    logic                cpu_gnt;
    logic                cpu_rvalid;
    logic [WIDTH-1:0]    cpu_rdata;

    // Host / loader port (half-word wide)
    logic                host_req;
    logic                host_we;
    logic                host_hi;
    logic [ADD_SIZE-1:0] host_addr;
    logic [15:0]         host_wdata;
    logic                host_gnt;
    logic                host_rvalid;
    logic [15:0]         host_rdata;

    // imem command and read data
    logic                mem_cs;
    logic [1:0]          mem_wen;
    logic [ADD_SIZE-1:0] mem_address;
    logic [WIDTH-1:0]    mem_d;
    logic [WIDTH-1:0]    mem_q;

    // Controller view
    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  host_req, host_we, host_hi, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_cs, mem_wen, mem_address, mem_d,
        input  mem_q
    );

    // Environment view: requesters plus the memory itself
    modport master (
        output cpu_req, cpu_addr,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output host_req, host_we, host_hi, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_cs, mem_wen, mem_address, mem_d,
        output mem_q
    );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction-memory front end. Arbitrates the single-ported imem between
// the CPU fetch port and the host/loader port, registers the memory command
// (stage 1) and steers the registered imem read data back to the requester
// that issued it (stage 2). Read latency is two cycles from the accept edge.
module imem_ctrl #(
    parameter int WIDTH      = 28,
    parameter int ADD_SIZE   = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    imem_ctrl_if.slave  bus
);

    // Upper half-word is narrower than 16 bits and the host bus is 16 bits,
    // so the packing below only makes sense inside this range.
    if (WIDTH <= 16 || WIDTH > 32) begin : g_bad_width
        $error("imem_ctrl: WIDTH must be in 17..32");
    end

    localparam int UW = WIDTH - 16;  // upper half width
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    // Kind of command travelling down the pipeline.
    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_CPU_RD  = 2'd1,
        CMD_HOST_RD = 2'd2,
        CMD_HOST_WR = 2'd3
    } cmd_e;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
    logic                cpu_gnt, host_gnt;

    // ------------------------------------------------------------------
    // Stage 1: registered memory command
    // ------------------------------------------------------------------
    cmd_e                s1_cmd_q, s1_cmd_d;
    logic                s1_hi_q, s1_hi_d;
    logic                mem_cs_q, mem_cs_d;
    logic [1:0]          mem_wen_q, mem_wen_d;
    logic [ADD_SIZE-1:0] mem_address_q, mem_address_d;
    logic [WIDTH-1:0]    mem_d_q, mem_d_d;

    // ------------------------------------------------------------------
    // Stage 2: read-return tag and held read data
    // ------------------------------------------------------------------
    cmd_e                s2_cmd_q, s2_cmd_d;
    logic                s2_hi_q, s2_hi_d;
    logic [WIDTH-1:0]    cpu_hold_q, cpu_hold_d;
    logic [15:0]         host_hold_q, host_hold_d;

    logic                cpu_rvalid, host_rvalid;
    logic [WIDTH-1:0]    cpu_rdata;
    logic [15:0]         host_rdata;
    logic [15:0]         host_sel;

    // Grant: host wins when the CPU is idle or the host has already lost
    // STARVE_MAX cycles in a row; nobody is granted while in reset.
    always_comb begin
        host_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (!reset) begin
            host_gnt = bus.host_req && (!bus.cpu_req || (starve_cnt_q >= STARVE_LIM));
            cpu_gnt  = bus.cpu_req && !host_gnt;
        end
    end

    // Count consecutive host losses, saturating; any host win or idle clears it.
    always_comb begin
        starve_cnt_d = '0;
        if (bus.host_req && !host_gnt) begin
            if (starve_cnt_q >= STARVE_LIM) begin
                starve_cnt_d = STARVE_LIM;
            end else begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // Build the next memory command from the accepted request; address and
    // write data hold when nothing is accepted.
    always_comb begin
        s1_cmd_d      = CMD_NONE;
        s1_hi_d       = 1'b0;
        mem_cs_d      = 1'b0;
        mem_wen_d     = 2'b00;
        mem_address_d = mem_address_q;
        mem_d_d       = mem_d_q;
        if (cpu_gnt) begin
            s1_cmd_d      = CMD_CPU_RD;
            mem_cs_d      = 1'b1;
            mem_address_d = bus.cpu_addr;
        end else if (host_gnt) begin
            mem_cs_d      = 1'b1;
            mem_address_d = bus.host_addr;
            s1_hi_d       = bus.host_hi;
            if (bus.host_we) begin
                s1_cmd_d = CMD_HOST_WR;
                if (bus.host_hi) begin
                    mem_wen_d = 2'b10;
                    mem_d_d   = {bus.host_wdata[UW-1:0], 16'h0000};
                end else begin
                    mem_wen_d = 2'b01;
                    mem_d_d   = WIDTH'(bus.host_wdata);
                end
            end else begin
                s1_cmd_d = CMD_HOST_RD;
            end
        end
    end

    // Only reads produce a return; the tag follows the command by one cycle,
    // which is exactly when imem presents mem_q.
    always_comb begin
        s2_cmd_d = CMD_NONE;
        s2_hi_d  = 1'b0;
        if (s1_cmd_q == CMD_CPU_RD || s1_cmd_q == CMD_HOST_RD) begin
            s2_cmd_d = s1_cmd_q;
            s2_hi_d  = s1_hi_q;
        end
    end

    // Steer mem_q to the owner of the returning read; otherwise replay the
    // last delivered value so rdata stays put between pulses.
    always_comb begin
        cpu_rvalid  = (s2_cmd_q == CMD_CPU_RD);
        host_rvalid = (s2_cmd_q == CMD_HOST_RD);
        host_sel    = s2_hi_q ? 16'(bus.mem_q[WIDTH-1:16]) : bus.mem_q[15:0];
        cpu_rdata   = cpu_rvalid  ? bus.mem_q : cpu_hold_q;
        host_rdata  = host_rvalid ? host_sel  : host_hold_q;
        cpu_hold_d  = cpu_rdata;
        host_hold_d = host_rdata;
    end

    // Arbitration counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Stage 1 registers; reset drops any command about to issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_cmd_q      <= CMD_NONE;
            s1_hi_q       <= 1'b0;
            mem_cs_q      <= 1'b0;
            mem_wen_q     <= 2'b00;
            mem_address_q <= '0;
            mem_d_q       <= '0;
        end else begin
            s1_cmd_q      <= s1_cmd_d;
            s1_hi_q       <= s1_hi_d;
            mem_cs_q      <= mem_cs_d;
            mem_wen_q     <= mem_wen_d;
            mem_address_q <= mem_address_d;
            mem_d_q       <= mem_d_d;
        end
    end

    // Stage 2 registers; reset flushes any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_cmd_q    <= CMD_NONE;
            s2_hi_q     <= 1'b0;
            cpu_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            s2_cmd_q    <= s2_cmd_d;
            s2_hi_q     <= s2_hi_d;
            cpu_hold_q  <= cpu_hold_d;
            host_hold_q <= host_hold_d;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.cpu_gnt     = cpu_gnt;
        bus.host_gnt    = host_gnt;
        bus.cpu_rvalid  = cpu_rvalid;
        bus.cpu_rdata   = cpu_rdata;
        bus.host_rvalid = host_rvalid;
        bus.host_rdata  = host_rdata;
        bus.mem_cs      = mem_cs_q;
        bus.mem_wen     = mem_wen_q;
        bus.mem_address = mem_address_q;
        bus.mem_d       = mem_d_q;
    end

    // Structural invariants of the arbiter and return path.
    a_one_grant  : assert property (@(posedge clk) !(cpu_gnt && host_gnt));
    a_one_rvalid : assert property (@(posedge clk) !(cpu_rvalid && host_rvalid));

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model (memory array updated in
// accept order, reads returned two cycles after accept).
module tb_imem_ctrl;

    localparam int WIDTH    = 28;
    localparam int ADD_SIZE = 11;
    localparam int STARVE   = 4;
    localparam int DEPTH    = 1 << ADD_SIZE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_ctrl_if #(.WIDTH(WIDTH), .ADD_SIZE(ADD_SIZE)) bus ();
    imem_ctrl_if #(.WIDTH(WIDTH), .ADD_SIZE(ADD_SIZE)) bus0 ();

    imem_ctrl #(.WIDTH(WIDTH), .ADD_SIZE(ADD_SIZE), .STARVE_MAX(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance with host-always-wins arbitration; only its grants matter.
    imem_ctrl #(.WIDTH(WIDTH), .ADD_SIZE(ADD_SIZE), .STARVE_MAX(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    assign bus0.cpu_req    = bus.cpu_req;
    assign bus0.cpu_addr   = bus.cpu_addr;
    assign bus0.host_req   = bus.host_req;
    assign bus0.host_we    = bus.host_we;
    assign bus0.host_hi    = bus.host_hi;
    assign bus0.host_addr  = bus.host_addr;
    assign bus0.host_wdata = bus.host_wdata;
    assign bus0.mem_q      = '0;

    // ---------------- imem behavioural model ----------------
    logic [WIDTH-1:0] imem [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_wen[0]) imem[bus.mem_address][15:0] = bus.mem_d[15:0];
            if (bus.mem_wen[1]) imem[bus.mem_address][WIDTH-1:16] = bus.mem_d[WIDTH-1:16];
            if (bus.mem_wen == 2'b00) bus.mem_q <= imem[bus.mem_address];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    rd_t              cpu_exp_q[$];
    rd_t              host_exp_q[$];
    int               cyc;
    int               host_losses;
    bit               model_valid;
    logic             exp_cs;
    logic [1:0]       exp_wen;
    logic [ADD_SIZE-1:0] exp_addr;
    logic [WIDTH-1:0] exp_d;
    logic [WIDTH-1:0] last_cpu;
    logic [15:0]      last_host;
    logic             seen_hgnt;
    logic             seen_hgnt0;
    int               n_vec;
    int               n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then
    // advance the model across the rising edge. Returns the model's grants.
    task automatic step(input logic rst,
                        input logic c_req, input logic [ADD_SIZE-1:0] c_addr,
                        input logic h_req, input logic h_we, input logic h_hi,
                        input logic [ADD_SIZE-1:0] h_addr, input logic [15:0] h_wd,
                        output logic c_won, output logic h_won);
        logic e_h, e_c, rv;
        logic [ADD_SIZE-1:0] a;
        rd_t r;
        reset           = rst;
        bus.cpu_req     = c_req;
        bus.cpu_addr    = c_addr;
        bus.host_req    = h_req;
        bus.host_we     = h_we;
        bus.host_hi     = h_hi;
        bus.host_addr   = h_addr;
        bus.host_wdata  = h_wd;
        @(negedge clk);

        e_h = !rst && h_req && (!c_req || host_losses >= STARVE);
        e_c = !rst && c_req && !e_h;
        check_eq("host_gnt", bus.host_gnt, e_h);
        check_eq("cpu_gnt", bus.cpu_gnt, e_c);
        check_eq("host_gnt_s0", bus0.host_gnt, !rst && h_req);
        check_eq("cpu_gnt_s0", bus0.cpu_gnt, !rst && c_req && !h_req);
        seen_hgnt  = bus.host_gnt;
        seen_hgnt0 = bus0.host_gnt;

        if (model_valid) begin
            rv = (cpu_exp_q.size() > 0) && (cpu_exp_q[0].due == cyc);
            check_eq("cpu_rvalid", bus.cpu_rvalid, rv);
            if (rv) begin
                r = cpu_exp_q.pop_front();
                last_cpu = r.data[WIDTH-1:0];
            end
            check_eq("cpu_rdata", bus.cpu_rdata, last_cpu);
            rv = (host_exp_q.size() > 0) && (host_exp_q[0].due == cyc);
            check_eq("host_rvalid", bus.host_rvalid, rv);
            if (rv) begin
                r = host_exp_q.pop_front();
                last_host = r.data[15:0];
            end
            check_eq("host_rdata", bus.host_rdata, last_host);
            check_eq("mem_cs", bus.mem_cs, exp_cs);
            check_eq("mem_wen", bus.mem_wen, exp_wen);
            check_eq("mem_address", bus.mem_address, exp_addr);
            check_eq("mem_d", bus.mem_d, exp_d);
        end

        if (rst) begin
            cpu_exp_q.delete();
            host_exp_q.delete();
            host_losses = 0;
            exp_cs      = 1'b0;
            exp_wen     = 2'b00;
            exp_addr    = '0;
            exp_d       = '0;
            last_cpu    = '0;
            last_host   = '0;
            model_valid = 1'b1;
        end else begin
            exp_cs  = e_c || e_h;
            exp_wen = 2'b00;
            if (e_c) begin
                exp_addr = c_addr;
                cpu_exp_q.push_back('{due: cyc + 2, data: 32'(ref_mem[c_addr])});
            end
            if (e_h) begin
                a = h_addr;
                exp_addr = a;
                if (h_we && h_hi) begin
                    ref_mem[a][WIDTH-1:16] = h_wd[WIDTH-17:0];
                    exp_d   = {h_wd[WIDTH-17:0], 16'h0000};
                    exp_wen = 2'b10;
                end else if (h_we) begin
                    ref_mem[a][15:0] = h_wd;
                    exp_d   = WIDTH'(h_wd);
                    exp_wen = 2'b01;
                end else if (h_hi) begin
                    host_exp_q.push_back('{due: cyc + 2, data: 32'(ref_mem[a][WIDTH-1:16])});
                end else begin
                    host_exp_q.push_back('{due: cyc + 2, data: 32'(ref_mem[a][15:0])});
                end
            end
            if (h_req && !e_h) host_losses++;
            else host_losses = 0;
        end
        c_won = e_c;
        h_won = e_h;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        logic cw, hw;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 16'h0, cw, hw);
    endtask

    task automatic cpu_rd(input logic [ADD_SIZE-1:0] a);
        logic cw, hw;
        step(1'b0, 1'b1, a, 1'b0, 1'b0, 1'b0, '0, 16'h0, cw, hw);
    endtask

    task automatic host_op(input logic we, input logic hi, input logic [ADD_SIZE-1:0] a,
                           input logic [15:0] wd);
        logic cw, hw;
        step(1'b0, 1'b0, '0, 1'b1, we, hi, a, wd, cw, hw);
    endtask

    task automatic preload(input int a, input logic [WIDTH-1:0] v);
        imem[a]    = v;
        ref_mem[a] = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic cw, hw;
        logic c_req, h_req, h_we, h_hi;
        logic [ADD_SIZE-1:0] c_addr, h_addr;
        logic [15:0] h_wd;
        logic [11:0] pattern;
        int n0;

        n_vec = 0;
        n_err = 0;
        cyc = 0;
        host_losses = 0;
        model_valid = 1'b0;
        exp_cs = 1'b0; exp_wen = 2'b00; exp_addr = '0; exp_d = '0;
        last_cpu = '0; last_host = '0;
        for (int i = 0; i < DEPTH; i++) preload(i, WIDTH'($urandom));

        // Reset with both requesters asserted: no grants, everything zero.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 11'd3, 1'b1, 1'b0, 1'b0, 11'd9, 16'h0, cw, hw);
        idle(1);

        // CPU streaming from preloaded words.
        preload(0, 28'h1234567);
        preload(1, 28'hABCDEF0);
        preload(2, 28'h0000001);
        preload(3, 28'hFFFFFFF);
        for (int i = 0; i < 4; i++) cpu_rd(ADD_SIZE'(i));
        idle(3);
        check_eq("stream_last", bus.cpu_rdata, 32'h0FFFFFFF);

        // Host half-word writes and read-backs at the top address.
        host_op(1'b1, 1'b0, 11'h7FF, 16'hBEEF);
        host_op(1'b1, 1'b1, 11'h7FF, 16'h0A5C);
        cpu_rd(11'h7FF);
        idle(3);
        check_eq("full_word_7ff", bus.cpu_rdata, 32'h0A5CBEEF);
        host_op(1'b0, 1'b0, 11'h7FF, 16'h0);
        idle(3);
        check_eq("host_lo_7ff", bus.host_rdata, 32'hBEEF);
        host_op(1'b0, 1'b1, 11'h7FF, 16'h0);
        idle(3);
        check_eq("host_hi_7ff", bus.host_rdata, 32'h0A5C);

        // Contention: both requesting for 12 cycles.
        c_addr = 11'd0; h_addr = 11'd1;
        pattern = '0;
        n0 = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, c_addr, 1'b1, 1'b0, i[0], h_addr, 16'h0, cw, hw);
            pattern[i] = seen_hgnt;
            if (seen_hgnt0) n0++;
            if (cw) c_addr = ADD_SIZE'($urandom_range(0, 7));
            if (hw) h_addr = ADD_SIZE'($urandom_range(0, 7));
        end
        idle(3);
        check_eq("contention_pattern", pattern, 32'h210);
        check_eq("host_always_wins", n0, 12);

        // Write followed immediately by a read of the same address.
        host_op(1'b1, 1'b0, 11'd5, 16'h1111);
        cpu_rd(11'd5);
        idle(3);
        check_eq("raw_hazard", bus.cpu_rdata[15:0], 32'h1111);

        // Reset while a read is in flight, then stream again.
        cpu_rd(11'd2);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 16'h0, cw, hw);
        idle(4);
        for (int i = 0; i < 4; i++) cpu_rd(ADD_SIZE'(i));
        idle(3);
        check_eq("stream_after_reset", bus.cpu_rdata, 32'h0FFFFFFF);

        // Randomized traffic with occasional resets.
        c_req = 1'b0; h_req = 1'b0; h_we = 1'b0; h_hi = 1'b0;
        c_addr = '0; h_addr = '0; h_wd = '0;
        for (int i = 0; i < 800; i++) begin
            if (!c_req) begin
                c_req  = ($urandom_range(0, 3) != 0);
                c_addr = ADD_SIZE'($urandom_range(0, 15));
            end
            if (!h_req) begin
                h_req  = ($urandom_range(0, 1) != 0);
                h_we   = ($urandom_range(0, 1) != 0);
                h_hi   = ($urandom_range(0, 1) != 0);
                h_addr = ($urandom_range(0, 9) == 0) ? 11'h7FF : ADD_SIZE'($urandom_range(0, 15));
                h_wd   = 16'($urandom);
            end
            step(($urandom_range(0, 199) == 0), c_req, c_addr, h_req, h_we, h_hi, h_addr, h_wd, cw, hw);
            if (cw) c_req = 1'b0;
            if (hw) h_req = 1'b0;
        end
        idle(4);
        check_eq("cpu_queue_drained", cpu_exp_q.size(), 0);
        check_eq("host_queue_drained", host_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
